// File: rtl/imem_loader.sv
// imem_loader: instruction-memory writer fed by a byte stream.
// Image format is a 16-bit little-endian word count N followed by N
// little-endian 32-bit words. Words are written to consecutive addresses
// starting at BASE_WORD, and the CPU is held in stall while loading.
// Optional build macro IMEM_LOADER_CKSUM_EN adds a trailing XOR checksum
// byte, which is checked after the last data word.
module imem_loader #(
  parameter int ADDR_W    = 11,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [31:0]       im_a,
  output logic [31:0]       im_wd,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // Number of words that fit between BASE_WORD and the top of the RAM.
  localparam logic [31:0] CAPACITY = 32'((1 << ADDR_W) - BASE_WORD);
  localparam logic [31:0] BASE_C   = 32'(BASE_WORD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN0   = 3'd1,
    S_LEN1   = 3'd2,
    S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM  = 3'd5,
`endif
    S_FINISH = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [15:0] length_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] asm_q;        // low three bytes of the word being assembled
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  cksum_q;      // running XOR of all accepted data bytes
`endif

  logic              accept;
  logic [15:0]       len_full;
  logic              len_zero;
  logic              len_over;
  logic [ADDR_W:0]   wl_inc;
  logic              last_word;
  logic              word_done;

  assign accept    = in_valid & in_ready;
  // Full length as it becomes known on the LEN1 acceptance edge.
  assign len_full  = {in_data, length_q[7:0]};
  assign len_zero  = (len_full == 16'd0);
  assign len_over  = (32'(len_full) > CAPACITY);
  assign wl_inc    = words_loaded + 1'b1;
  assign last_word = (32'(wl_inc) == 32'(length_q));
  // Fourth byte of a word accepted: the word is complete this edge.
  assign word_done = accept && (state_q == S_DATA) && (byte_idx_q == 2'd3);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (accept) state_d = S_LEN1;
      end
      S_LEN1: begin
        if (accept) begin
          if (len_zero) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_FINISH;
`endif
          end else if (len_over) begin
            // Oversize image: refuse it without touching memory or checksum.
            state_d = S_FINISH;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_done && last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_FINISH;
`endif
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (accept) state_d = S_FINISH;
      end
`endif
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Byte acceptance: ready in every state that consumes stream bytes
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN0,
      S_LEN1,
      S_DATA:  in_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: in_ready = 1'b1;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  // Length capture, word assembly, RAM write port and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length_q     <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      im_we        <= 1'b0;
      im_a         <= '0;
      im_wd        <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum_q      <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse per completed word.
      im_we <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byte_idx_q   <= '0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q      <= '0;
`endif
          end
        end
        S_LEN0: begin
          if (accept) length_q[7:0] <= in_data;
        end
        S_LEN1: begin
          if (accept) begin
            length_q[15:8] <= in_data;
            if (len_over) err <= 1'b1;
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q    <= cksum_q ^ in_data;
`endif
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              default: begin
                // Assembly register and write register are separate, so the
                // next byte can be accepted while this word is being written.
                im_we        <= 1'b1;
                im_wd        <= {in_data, asm_q};
                im_a         <= (BASE_C + 32'(words_loaded)) << 2;
                words_loaded <= wl_inc;
              end
            endcase
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (accept && (in_data != cksum_q)) err <= 1'b1;
        end
`endif
        S_FINISH: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (default parameters ADDR_W=11, BASE_WORD=0).
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_a;
  logic [31:0] im_wd;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] words_loaded;

  int n_cmp;
  int n_mis;

  logic [31:0] wr_a [16];
  logic [31:0] wr_d [16];
  int          wr_n;

  imem_loader #(.ADDR_W(11), .BASE_WORD(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .im_we        (im_we),
    .im_a         (im_a),
    .im_wd        (im_wd),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (im_we === 1'b1 && wr_n < 16) begin
      wr_a[wr_n] = im_a;
      wr_d[wr_n] = im_wd;
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    if (n >= 20) check("ready_wait", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},  32'(in_ready), 32'd0);
    check({tag, "_we"},   32'(im_we), 32'd0);
    check({tag, "_a"},    im_a, 32'd0);
    check({tag, "_wd"},   im_wd, 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"},  32'(err), 32'd0);
    check({tag, "_wl"},   32'(words_loaded), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_mis    = 0;
    wr_n     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;

    #3 check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word image
    wr_n = 0;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h90);
`endif
    @(posedge clk); #1;
    check("t1_done", 32'(done), 32'd1);
    check("t1_err",  32'(err), 32'd0);
    check("t1_busy0", 32'(busy), 32'd0);
    check("t1_hold0", 32'(cpu_hold), 32'd0);
    check("t1_wl",   32'(words_loaded), 32'd2);
    check("t1_nwr",  32'(wr_n), 32'd2);
    check("t1_a0",   wr_a[0], 32'h0000_0000);
    check("t1_d0",   wr_d[0], 32'h0000_0013);
    check("t1_a1",   wr_a[1], 32'h0000_0004);
    check("t1_d1",   wr_d[1], 32'h0010_0093);

    // Oversize length 2049 words
    wr_n = 0;
    pulse_start();
    check("t2_done0", 32'(done), 32'd0);
    send_byte(8'h01); send_byte(8'h08);
    @(posedge clk); #1;
    check("t2_done", 32'(done), 32'd1);
    check("t2_err",  32'(err), 32'd1);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t2_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("t2_nwr", 32'(wr_n), 32'd0);
    check("t2_wl",  32'(words_loaded), 32'd0);

    // Zero-length image: done three cycles after start
    wr_n = 0;
    pulse_start();
    check("t3_err0", 32'(err), 32'd0);
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h00);
`endif
    check("t3_done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("t3_done", 32'(done), 32'd1);
    check("t3_err",  32'(err), 32'd0);
    check("t3_nwr",  32'(wr_n), 32'd0);

    // Three words with gaps in in_valid, plus a stray start mid-load
    wr_n = 0;
    pulse_start();
    send_byte(8'h03); send_byte(8'h00);
    send_word(32'hDEAD_BEEF, 2);
    send_byte(8'h00);
    pulse_start();
    check("t4_busy_mid", 32'(busy), 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_word(32'hFFFF_FFFF, 3);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h22);
`endif
    @(posedge clk); #1;
    check("t4_done", 32'(done), 32'd1);
    check("t4_err",  32'(err), 32'd0);
    check("t4_wl",   32'(words_loaded), 32'd3);
    check("t4_nwr",  32'(wr_n), 32'd3);
    check("t4_a0", wr_a[0], 32'h0000_0000);
    check("t4_d0", wr_d[0], 32'hDEAD_BEEF);
    check("t4_a1", wr_a[1], 32'h0000_0004);
    check("t4_d1", wr_d[1], 32'h0000_0000);
    check("t4_a2", wr_a[2], 32'h0000_0008);
    check("t4_d2", wr_d[2], 32'hFFFF_FFFF);

    // Asynchronous reset after 6 of 8 data bytes, then a clean reload
    wr_n = 0;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    send_byte(8'hA5); send_byte(8'hA5);
    check("t5_wl_pre", 32'(words_loaded), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t5_arst");
    @(negedge clk);
    rst_n = 1'b1;
    wr_n = 0;
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_word(32'h0102_0304, 0);
    send_word(32'hA5A5_A5A5, 0);
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(8'h04);
`endif
    @(posedge clk); #1;
    check("t5_done", 32'(done), 32'd1);
    check("t5_err",  32'(err), 32'd0);
    check("t5_nwr",  32'(wr_n), 32'd2);
    check("t5_a1",   wr_a[1], 32'h0000_0004);
    check("t5_d0",   wr_d[0], 32'h0102_0304);
    check("t5_d1",   wr_d[1], 32'hA5A5_A5A5);

`ifdef IMEM_LOADER_CKSUM_EN
    // Checksum good and bad
    wr_n = 0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h1122_3344, 0);
    send_byte(8'h44);
    @(posedge clk); #1;
    check("t6_done", 32'(done), 32'd1);
    check("t6_err",  32'(err), 32'd0);
    wr_n = 0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h1122_3344, 0);
    send_byte(8'h45);
    @(posedge clk); #1;
    check("t6b_done", 32'(done), 32'd1);
    check("t6b_err",  32'(err), 32'd1);
    check("t6b_nwr",  32'(wr_n), 32'd1);
    check("t6b_d0",   wr_d[0], 32'h1122_3344);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
